// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle add/subtract controller that time-shares one external 4-bit
// carry-lookahead slice, one nibble per cycle, LSB first.
module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_sum,
  input  logic             slice_cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   result_r;
  logic               busy_r;
  logic               done_r;
  logic               cout_r;
  logic               overflow_r;
  logic               accept_s;
  logic [IDX_W+1:0]   base_s;
  logic [3:0]         slice_a_s;
  logic [3:0]         slice_b_s;
  logic               slice_cin_s;

  // A request is only taken when no operation is in flight.
  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign base_s   = {idx_r, 2'b00};

  // Present the current nibble pair and inter-nibble carry to the slice; quiet outside RUN.
  always_comb begin
    slice_a_s   = 4'd0;
    slice_b_s   = 4'd0;
    slice_cin_s = 1'b0;
    if (state_r == ST_RUN) begin
      slice_a_s   = a_r[base_s +: 4];
      slice_b_s   = b_r[base_s +: 4];
      slice_cin_s = carry_r;
    end else begin
      slice_a_s   = 4'd0;
      slice_b_s   = 4'd0;
      slice_cin_s = 1'b0;
    end
  end

  // Sequencer FSM: operand capture, per-nibble accumulation and flag generation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      carry_r    <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      result_r   <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      cout_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else if (accept_s) begin
      // Subtraction is a + ~b + 1, so the +1 rides in on the initial carry.
      a_r        <= op_a;
      b_r        <= sub ? ~op_b : op_b;
      carry_r    <= sub ? 1'b1 : cin;
      idx_r      <= '0;
      result_r   <= '0;
      cout_r     <= 1'b0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      state_r    <= ST_RUN;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        ST_RUN: begin
          result_r[base_s +: 4] <= slice_sum;
          carry_r               <= slice_cout;
          idx_r                 <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          if (idx_r == LAST_IDX) begin
            state_r    <= ST_DONE;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            cout_r     <= slice_cout;
            // slice_sum[3] is the result MSB being written on this edge.
            overflow_r <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (slice_sum[3] != a_r[WIDTH-1]);
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign cout      = cout_r;
  assign overflow  = overflow_r;
  assign slice_a   = slice_a_s;
  assign slice_b   = slice_b_s;
  assign slice_cin = slice_cin_s;

endmodule
